alpha_blend_pipe: RTL and testbench

- Parametrised, fully pipelined alpha compositor for the LED colour path.
- Accepts one top/bottom pixel pair per cycle over a valid/ready handshake.
- Each channel is blended, added with saturation, multiplied, or passed through, selected per pixel by a mode field.
- Sits between the layer/pattern generators and the LED frame buffer writer.
- Replaces the single-shot blender: sustains throughput 1 pixel/clk and supports backpressure.

---
 rtl/alpha_blend_pkg.sv | 14 +
 rtl/alpha_blend_pipe_channel.sv | 60 ++++++
 rtl/alpha_blend_pipe.sv | 81 ++++++++
 tb/tb_alpha_blend_pipe.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alpha_blend_pkg.sv
// Shared constants for the LED-path alpha compositor.
// Mode encodings travel with each pixel through the pipe.
package alpha_blend_pkg;

    localparam int MODE_W = 2;

    typedef logic [MODE_W-1:0] mode_t;

    localparam mode_t MODE_BLEND    = 2'd0;
    localparam mode_t MODE_ADD_SAT  = 2'd1;
    localparam mode_t MODE_MUL      = 2'd2;
    localparam mode_t MODE_PASS_BOT = 2'd3;

endpackage

// File: rtl/alpha_blend_pipe_channel.sv
// One colour channel: stage-1 products and stage-2 combine/round/saturate.
// Purely combinational; the registers between the halves live in the top.
module blend_channel
    import alpha_blend_pkg::*;
#(
    parameter int CH_W = 8
) (
    input  logic [CH_W-1:0]   top,
    input  logic [CH_W-1:0]   bot,
    input  logic [CH_W-1:0]   alpha,
    output logic [2*CH_W-1:0] prod_ta,
    output logic [2*CH_W-1:0] prod_bma,
    output logic [2*CH_W-1:0] prod_tb,
    input  logic [2*CH_W-1:0] s1_ta,
    input  logic [2*CH_W-1:0] s1_bma,
    input  logic [2*CH_W-1:0] s1_tb,
    input  logic [CH_W-1:0]   s1_bot,
    input  mode_t             s1_mode,
    output logic [CH_W-1:0]   result
);

    localparam logic [CH_W-1:0] MAXV = '1;
    localparam logic [CH_W:0]   ZPAD = '0;

    logic [CH_W-1:0]   inv_alpha;
    logic [2*CH_W:0]   blend_sum;
    logic [2*CH_W:0]   ta_round;
    logic [2*CH_W:0]   tb_round;
    logic [CH_W:0]     add_sum;
    logic [CH_W-1:0]   add_sat;
    logic              unused_bits;

    assign inv_alpha = MAXV - alpha;
    assign prod_ta   = {{CH_W{1'b0}}, top} * {{CH_W{1'b0}}, alpha};
    assign prod_bma  = {{CH_W{1'b0}}, bot} * {{CH_W{1'b0}}, inv_alpha};
    assign prod_tb   = {{CH_W{1'b0}}, top} * {{CH_W{1'b0}}, bot};

    // Adding M before the shift makes alpha=M return top exactly and alpha=0 return bot.
    assign blend_sum = {1'b0, s1_ta} + {1'b0, s1_bma} + {ZPAD[CH_W-1:0], 1'b0, MAXV};
    assign ta_round  = {1'b0, s1_ta} + {ZPAD[CH_W-1:0], 1'b0, MAXV};
    assign tb_round  = {1'b0, s1_tb} + {ZPAD[CH_W-1:0], 1'b0, MAXV};
    assign add_sum   = {1'b0, s1_bot} + {1'b0, ta_round[2*CH_W-1:CH_W]};
    assign add_sat   = add_sum[CH_W] ? MAXV : add_sum[CH_W-1:0];

    // Every rounded sum is bounded by M*(M+1), so the top bit and low half are never needed.
    assign unused_bits = ^{blend_sum[2*CH_W], blend_sum[CH_W-1:0],
                           ta_round[2*CH_W], ta_round[CH_W-1:0],
                           tb_round[2*CH_W], tb_round[CH_W-1:0]};

    always_comb begin
        result = s1_bot;
        case (s1_mode)
            MODE_BLEND:   result = blend_sum[2*CH_W-1:CH_W];
            MODE_ADD_SAT: result = add_sat;
            MODE_MUL:     result = tb_round[2*CH_W-1:CH_W];
            default:      result = s1_bot;
        endcase
    end

endmodule

// File: rtl/alpha_blend_pipe.sv
// Two-stage alpha compositor, one pixel per clock with valid/ready backpressure.
// The whole pipe advances or holds as one, so in_ready depends only on the output side.
module alpha_blend_pipe
    import alpha_blend_pkg::*;
#(
    parameter int CH_W    = 8,
    parameter int NUM_CH  = 3,
    parameter int ALPHA_W = CH_W
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NUM_CH*CH_W-1:0] color_top,
    input  logic [NUM_CH*CH_W-1:0] color_bot,
    input  logic [ALPHA_W-1:0]     alpha,
    input  logic [MODE_W-1:0]      mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM_CH*CH_W-1:0] color_out
);

    localparam int PW    = 2*CH_W;
    localparam int PIX_W = NUM_CH*CH_W;

    logic              advance;
    logic              s1_valid;
    mode_t             s1_mode;
    logic [PIX_W-1:0]  s1_bot;
    logic [PIX_W-1:0]  result;
    logic [NUM_CH*PW-1:0] prod_ta, prod_bma, prod_tb;
    logic [NUM_CH*PW-1:0] s1_ta, s1_bma, s1_tb;

    assign advance  = !(out_valid && !out_ready);
    assign in_ready = advance;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        blend_channel #(.CH_W(CH_W)) u_ch (
            .top      (color_top[c*CH_W +: CH_W]),
            .bot      (color_bot[c*CH_W +: CH_W]),
            .alpha    (alpha),
            .prod_ta  (prod_ta[c*PW +: PW]),
            .prod_bma (prod_bma[c*PW +: PW]),
            .prod_tb  (prod_tb[c*PW +: PW]),
            .s1_ta    (s1_ta[c*PW +: PW]),
            .s1_bma   (s1_bma[c*PW +: PW]),
            .s1_tb    (s1_tb[c*PW +: PW]),
            .s1_bot   (s1_bot[c*CH_W +: CH_W]),
            .s1_mode  (s1_mode),
            .result   (result[c*CH_W +: CH_W])
        );
    end

    // Data registers only load on a valid beat, so bubbles leave color_out untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_mode   <= MODE_BLEND;
            s1_bot    <= '0;
            s1_ta     <= '0;
            s1_bma    <= '0;
            s1_tb     <= '0;
            out_valid <= 1'b0;
            color_out <= '0;
        end else if (advance) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (in_valid) begin
                s1_mode <= mode;
                s1_bot  <= color_bot;
                s1_ta   <= prod_ta;
                s1_bma  <= prod_bma;
                s1_tb   <= prod_tb;
            end
            if (s1_valid) begin
                color_out <= result;
            end
        end
    end

endmodule

// File: tb/tb_alpha_blend_pipe.sv
// Self-checking bench for alpha_blend_pipe: vector table, backpressure, random, reset.
module tb_alpha_blend_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] color_top;
    logic [23:0] color_bot;
    logic [7:0]  alpha;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] color_out;

    alpha_blend_pipe #(.CH_W(8), .NUM_CH(3), .ALPHA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .color_top (color_top),
        .color_bot (color_bot),
        .alpha     (alpha),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .color_out (color_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] top;
        logic [23:0] bot;
        logic [7:0]  a;
        logic [1:0]  m;
        logic [23:0] exp;
    } vec_t;

    localparam int NV = 8;
    vec_t vec [NV];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          out_cnt = 0;
    int          stall_cnt = 0;
    logic [23:0] exp_q [$];
    logic [23:0] cur_exp;
    logic        prev_stall = 1'b0;
    logic [23:0] prev_color = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [23:0] model(input logic [23:0] t, input logic [23:0] b,
                                          input logic [7:0] a, input logic [1:0] m);
        logic [23:0] r;
        int tc, bc, ac, v;
        r  = '0;
        ac = int'(a);
        for (int c = 0; c < 3; c++) begin
            tc = int'(t[c*8 +: 8]);
            bc = int'(b[c*8 +: 8]);
            case (m)
                2'd0: v = (tc*ac + bc*(255-ac) + 255) / 256;
                2'd1: begin
                    v = bc + (tc*ac + 255) / 256;
                    if (v > 255) v = 255;
                end
                2'd2: v = (tc*bc + 255) / 256;
                default: v = bc;
            endcase
            r[c*8 +: 8] = 8'(v);
        end
        return r;
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard: pop on output transfer before pushing this cycle's input transfer.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in_ready_rule", {31'd0, in_ready}, {31'd0, !(out_valid && !out_ready)});
            if (prev_stall) begin
                chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
                chk("stall_hold_data", {8'd0, color_out}, {8'd0, prev_color});
            end
            if (out_valid && out_ready) begin
                out_cnt++;
                if (exp_q.size() == 0)
                    chk("unexpected_output", {8'd0, color_out}, 32'hDEAD_BEEF);
                else
                    chk("data", {8'd0, color_out}, {8'd0, exp_q.pop_front()});
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
            if (out_valid && !out_ready) stall_cnt++;
            prev_stall = out_valid && !out_ready;
            prev_color = color_out;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [23:0] t, input logic [23:0] b,
                         input logic [7:0] a, input logic [1:0] m, input logic [23:0] e);
        in_valid  = 1'b1;
        color_top = t;
        color_bot = b;
        alpha     = a;
        mode      = m;
        cur_exp   = e;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && n < 50) begin
            step();
            n++;
        end
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        int          lat, n, t0, sent, i, o0, s0;
        logic        acc;
        logic [23:0] t, b;
        logic [7:0]  a;
        logic [1:0]  m;

        vec[0] = '{24'hFF0000, 24'h0000FF, 8'h80, 2'd0, 24'h80007F};
        vec[1] = '{24'h123456, 24'hABCDEF, 8'hFF, 2'd0, 24'h123456};
        vec[2] = '{24'h123456, 24'hABCDEF, 8'h00, 2'd0, 24'hABCDEF};
        vec[3] = '{24'h808080, 24'hC01000, 8'hFF, 2'd1, 24'hFF9080};
        vec[4] = '{24'hFF8000, 24'h40FF40, 8'h33, 2'd2, 24'h408000};
        vec[5] = '{24'h123456, 24'hABCDEF, 8'h77, 2'd3, 24'hABCDEF};
        vec[6] = '{24'hFFFFFF, 24'h102030, 8'h00, 2'd1, 24'h102030};
        vec[7] = '{24'hFFFFFF, 24'hABCDEF, 8'h5A, 2'd2, 24'hABCDEF};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        color_top = '0;
        color_bot = '0;
        alpha     = '0;
        mode      = '0;
        cur_exp   = '0;

        // Reset state
        repeat (3) step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_color_out", {8'd0, color_out}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Single-pixel latency
        drive(vec[0].top, vec[0].bot, vec[0].a, vec[0].m, vec[0].exp);
        @(negedge clk);
        acc = in_ready;
        step();
        in_valid = 1'b0;
        chk("lat_accept", {31'd0, acc}, 32'd1);
        lat = 1;
        while (lat < 10) begin
            @(negedge clk);
            if (out_valid) break;
            lat++;
            step();
        end
        chk("latency", lat, 32'd2);
        chk("lat_color", {8'd0, color_out}, {8'd0, vec[0].exp});
        drain();

        // Table stream, back-to-back with out_ready high
        t0 = cyc;
        for (int k = 0; k < NV; k++) begin
            drive(vec[k].top, vec[k].bot, vec[k].a, vec[k].m, vec[k].exp);
            n = 0;
            do begin
                @(negedge clk);
                acc = in_ready;
                step();
                n++;
            end while (!acc && n < 20);
            chk("table_accept", {31'd0, acc}, 32'd1);
        end
        in_valid = 1'b0;
        chk("stream_cycles", cyc - t0, NV);
        drain();

        // Backpressure: 8 pixels, out_ready low in cycles 3..6
        o0 = out_cnt;
        s0 = stall_cnt;
        i  = 0;
        n  = 0;
        while ((i < 8 || exp_q.size() != 0 || out_valid) && n < 60) begin
            out_ready = !(n >= 3 && n <= 6);
            if (i < 8) begin
                t = 24'($urandom);
                b = 24'($urandom);
                a = 8'($urandom);
                m = 2'($urandom);
                drive(t, b, a, m, model(t, b, a, m));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            step();
            if (acc) i++;
            n++;
        end
        out_ready = 1'b1;
        chk("bp_outputs", out_cnt - o0, 32'd8);
        chk("bp_stalls", stall_cnt - s0, 32'd4);
        drain();

        // Random valid/ready toggling
        sent = 0;
        n    = 0;
        while (sent < 1000 && n < 20000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            t = 24'($urandom);
            b = 24'($urandom);
            case ($urandom_range(0, 5))
                0:       a = 8'h00;
                1:       a = 8'hFF;
                default: a = 8'($urandom);
            endcase
            m = 2'($urandom);
            color_top = t;
            color_bot = b;
            alpha     = a;
            mode      = m;
            cur_exp   = model(t, b, a, m);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            step();
            n++;
        end
        chk("random_sent", sent, 32'd1000);
        drain();

        // Reset with two pixels in flight
        o0 = out_cnt;
        out_ready = 1'b1;
        drive(vec[3].top, vec[3].bot, vec[3].a, vec[3].m, vec[3].exp);
        step();
        drive(vec[4].top, vec[4].bot, vec[4].a, vec[4].m, vec[4].exp);
        step();
        in_valid = 1'b0;
        chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_color_out", {8'd0, color_out}, 32'd0);
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (6) step();
        chk("post_rst_no_output", out_cnt - o0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
